hdd_usrcfg_resp: RTL and testbench
==================================

# hdd_usrcfg_resp

Slave-side responder for the 16-bit user control port that the camera controller drives into the HDD subsystem (tx_wr/txd strobe-write, rx_rd/rxd pull-read, 8-bit status). Incoming words are parsed into write or read packets. Writes go to an internal register bus with auto-incrementing address. Read results are buffered in a receive FIFO that the camera drains. The block sits inside hdd_main, between the user port pins and the HDD control register file.

## Interface
Parameters:
- G_RXFIFO_DEPTH, 16: read-response FIFO depth in words; power of two, 4..256.
- G_TMO, 1023: maximum cycles to wait for p_in_reg_rdy after a register read.

Ports:
- p_in_clk  in  1  single clock (same as p_in_usr_clk).
- p_in_rst  in  1  synchronous, active-high reset.
- p_in_usr_tx_wr  in  1  one-cycle write strobe from camera.
- p_in_usr_txd  in  16  write word, qualified by tx_wr.
- p_in_usr_rx_rd  in  1  one-cycle pop strobe from camera.
- p_out_usr_rxd  out  16  FIFO head word.
- p_out_usr_status  out  8  status; bits listed under Operation.
- p_out_reg_adr  out  8  register address.
- p_out_reg_d  out  16  register write data.
- p_out_reg_wr  out  1  register write pulse.
- p_out_reg_rd  out  1  register read request pulse.
- p_in_reg_d  in  16  register read data, qualified by reg_rdy.
- p_in_reg_rdy  in  1  read data valid, one-cycle pulse.

## Operation
Header word format:
- [15] dir: 0 = write, 1 = read.
- [14:8] cnt: word count minus 1, giving 1..128 words.
- [7:0] adr: start address.

Packet state machine (IDLE, WDATA, RREQ, RWAIT):
- IDLE: a tx_wr latches the header. It sets adr_cnt = adr and words_left = cnt+1, and clears the sticky error bits. Next state is WDATA if dir=0, RREQ if dir=1.
- WDATA: each tx_wr issues one register write (reg_d = txd, reg_adr = adr_cnt). Then adr_cnt increments (8-bit wrap, 0xFF -> 0x00) and words_left decrements. After the last word, return to IDLE. Cycles without tx_wr wait indefinitely.
- RREQ: if the FIFO is not full, pulse reg_rd with reg_adr = adr_cnt and go to RWAIT. If the FIFO is full, stay in RREQ and issue no request.
- RWAIT:
  - reg_rdy: push reg_d into the FIFO, increment adr_cnt, decrement words_left. Go to RREQ, or to IDLE after the last word.
  - Timeout (G_TMO cycles with no reg_rdy): push 16'hDEAD, set tmo_err, and advance exactly as for reg_rdy.
  - A reg_rdy outside RWAIT is ignored.
- tx_wr in RREQ or RWAIT: word discarded, proto_err set.

Receive FIFO (first-word-fall-through):
- p_out_usr_rxd shows the head word whenever not empty; it holds its last value when empty.
- rx_rd pops the head. rx_rd on empty: no pop, sets und_err.
- A push and a pop in the same cycle are both honoured; the count is unchanged.
- No overflow is possible because RREQ stalls while the FIFO is full.

Status bits:
- [0] FIFO not empty.
- [1] FIFO full.
- [2] busy (state != IDLE).
- [3] proto_err.
- [4] tmo_err.
- [5] und_err.
- [7:6] 0.

Bits [5:3] are sticky. They clear on reset or on acceptance of the next header; und_err is the exception and clears only on reset.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, all errors clear. A reset mid-packet aborts the packet and discards FIFO contents.
- Write path: reg_wr, reg_adr and reg_d are registered. They are asserted in the cycle after the tx_wr edge that carries the data word, for exactly one cycle.
- Read request: reg_rd is a one-cycle pulse, at earliest 1 cycle after entering RREQ. The header tx_wr edge is followed by reg_rd in the next cycle.
- Read data: a push on the reg_rdy edge makes the word visible on rxd and status[0] one cycle later.
- Pop: after rx_rd, the next head word appears on rxd one cycle later. Status is registered with the same one-cycle latency.
- Timeout counter: starts at 0 on RWAIT entry. The timeout fires at count G_TMO, and reg_rdy in that same cycle wins (real data, no error).
- Throughput: one write per cycle is sustained. Reads take at least 2 cycles per word.

## Test plan
- Write packet: header 16'h0210, then 0x1111, 0x2222, 0x3333 on consecutive cycles -> reg_wr pulses at adr 0x10/0x11/0x12 with that data, busy clear 1 cycle after the last word.
- Address wrap: header 16'h01FF, then 2 words -> writes at 0xFF then 0x00.
- Read packet with reg_rdy 3 cycles after each reg_rd: header 16'h8320, reg_d = adr*2 -> FIFO holds 0x0040, 0x0042, 0x0044, 0x0046; status[0]=1; 4 rx_rd pops return them in order; status[0]=0 afterwards.
- Backpressure: G_RXFIFO_DEPTH=4, read 8 words, no rx_rd -> exactly 4 reg_rd, status[1]=1, stall; popping 1 word releases exactly 1 further reg_rd.
- Errors:
  - reg_rdy never asserted -> after G_TMO cycles 16'hDEAD is pushed and status[4]=1.
  - tx_wr during RWAIT -> status[3]=1.
  - rx_rd on empty -> status[5]=1.
  - A new header clears [4:3] only.
- Reset mid read packet with 2 words in the FIFO -> all outputs 0 on the next cycle, status 0, a subsequent write packet works normally.

Source files
------------

// File: rtl/hdd_usrcfg_resp_if.sv
// Signal bundle between the camera user port / HDD register file and the
// user-config responder. The responder uses the slave modport.
interface hdd_usrcfg_resp_if;
  logic        p_in_usr_tx_wr;
  logic [15:0] p_in_usr_txd;
  logic        p_in_usr_rx_rd;
  logic [15:0] p_out_usr_rxd;
  logic [7:0]  p_out_usr_status;
  logic [7:0]  p_out_reg_adr;
  logic [15:0] p_out_reg_d;
  logic        p_out_reg_wr;
  logic        p_out_reg_rd;
  logic [15:0] p_in_reg_d;
  logic        p_in_reg_rdy;

  modport slave (
    input  p_in_usr_tx_wr, p_in_usr_txd, p_in_usr_rx_rd, p_in_reg_d, p_in_reg_rdy,
    output p_out_usr_rxd, p_out_usr_status, p_out_reg_adr, p_out_reg_d,
           p_out_reg_wr, p_out_reg_rd
  );

  modport master (
    output p_in_usr_tx_wr, p_in_usr_txd, p_in_usr_rx_rd, p_in_reg_d, p_in_reg_rdy,
    input  p_out_usr_rxd, p_out_usr_status, p_out_reg_adr, p_out_reg_d,
           p_out_reg_wr, p_out_reg_rd
  );
endinterface

// File: rtl/hdd_usrcfg_resp.sv
// User control port responder: parses header/data words into register
// writes or register reads, read results are queued in a FWFT receive FIFO.
//
// state   | meaning
// S_IDLE  | waiting for a header word
// S_WDATA | forwarding data words as register writes
// S_RREQ  | issuing the next register read once the FIFO has room
// S_RWAIT | waiting for read data or the timeout
module hdd_usrcfg_resp #(
  parameter int G_RXFIFO_DEPTH = 16,
  parameter int G_TMO          = 1023
) (
  input logic              p_in_clk,
  input logic              p_in_rst,
  hdd_usrcfg_resp_if.slave bus
);
  localparam int AW = $clog2(G_RXFIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(G_TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RREQ, S_RWAIT} state_t;

  state_t        r_state;
  logic [7:0]    r_adr_cnt;
  logic [7:0]    r_words_left;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_reg_adr;
  logic [15:0]   r_reg_d;
  logic          r_reg_wr;
  logic          r_reg_rd;
  logic          r_proto_err;
  logic          r_tmo_err;
  logic          r_und_err;

  logic [15:0]   r_mem [G_RXFIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_rxd;

  logic          w_empty;
  logic          w_full;
  logic          w_tmo_hit;
  logic          w_push;
  logic [15:0]   w_push_d;
  logic          w_pop;
  logic          w_last;
  logic [AW-1:0] w_rd_nxt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(G_RXFIFO_DEPTH));
  // Real data arriving in the timeout cycle takes precedence over the timeout.
  assign w_tmo_hit = (r_tmo_cnt == TW'(G_TMO)) && !bus.p_in_reg_rdy;
  assign w_push    = (r_state == S_RWAIT) && (bus.p_in_reg_rdy || w_tmo_hit);
  assign w_push_d  = bus.p_in_reg_rdy ? bus.p_in_reg_d : 16'hDEAD;
  assign w_pop     = bus.p_in_usr_rx_rd && !w_empty;
  assign w_last    = (r_words_left == 8'd1);
  assign w_rd_nxt  = r_rd_ptr + AW'(1);

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      r_state      <= S_IDLE;
      r_adr_cnt    <= '0;
      r_words_left <= '0;
      r_tmo_cnt    <= '0;
      r_reg_adr    <= '0;
      r_reg_d      <= '0;
      r_reg_wr     <= 1'b0;
      r_reg_rd     <= 1'b0;
      r_proto_err  <= 1'b0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_reg_wr <= 1'b0;
      r_reg_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.p_in_usr_tx_wr) begin
            r_adr_cnt    <= bus.p_in_usr_txd[7:0];
            r_words_left <= {1'b0, bus.p_in_usr_txd[14:8]} + 8'd1;
            r_proto_err  <= 1'b0;
            r_tmo_err    <= 1'b0;
            r_state      <= bus.p_in_usr_txd[15] ? S_RREQ : S_WDATA;
          end
        end
        S_WDATA: begin
          if (bus.p_in_usr_tx_wr) begin
            r_reg_wr     <= 1'b1;
            r_reg_adr    <= r_adr_cnt;
            r_reg_d      <= bus.p_in_usr_txd;
            r_adr_cnt    <= r_adr_cnt + 8'd1;
            r_words_left <= r_words_left - 8'd1;
            if (w_last) r_state <= S_IDLE;
          end
        end
        S_RREQ: begin
          if (bus.p_in_usr_tx_wr) r_proto_err <= 1'b1;
          if (!w_full) begin
            r_reg_rd  <= 1'b1;
            r_reg_adr <= r_adr_cnt;
            r_tmo_cnt <= '0;
            r_state   <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.p_in_usr_tx_wr) r_proto_err <= 1'b1;
          if (w_push) begin
            if (w_tmo_hit) r_tmo_err <= 1'b1;
            r_adr_cnt    <= r_adr_cnt + 8'd1;
            r_words_left <= r_words_left - 8'd1;
            r_state      <= w_last ? S_IDLE : S_RREQ;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge p_in_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_d;
  end

  // r_rxd tracks the head word so the output holds its last value when empty.
  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rxd     <= '0;
      r_und_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      if (bus.p_in_usr_rx_rd && w_empty) r_und_err <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_empty) begin
        if (w_push) r_rxd <= w_push_d;
      end else if (w_pop) begin
        if (r_count > CW'(1))
          r_rxd <= r_mem[w_rd_nxt];
        else if (w_push)
          r_rxd <= w_push_d;
      end
    end
  end

  assign bus.p_out_usr_rxd    = r_rxd;
  assign bus.p_out_usr_status = {2'b00, r_und_err, r_tmo_err, r_proto_err,
                                 (r_state != S_IDLE), w_full, !w_empty};
  assign bus.p_out_reg_adr    = r_reg_adr;
  assign bus.p_out_reg_d      = r_reg_d;
  assign bus.p_out_reg_wr     = r_reg_wr;
  assign bus.p_out_reg_rd     = r_reg_rd;
endmodule

// File: tb/tb_hdd_usrcfg_resp.sv
// Bench for hdd_usrcfg_resp: cycle vector table, directed corner sequences and
// random packets checked against a transaction-level model of the port.
module tb_hdd_usrcfg_resp;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdd_usrcfg_resp_if bus();

  hdd_usrcfg_resp #(.G_RXFIFO_DEPTH(DEPTH), .G_TMO(TMO)) dut (
    .p_in_clk(clk),
    .p_in_rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] q_wr[$];
  logic [7:0]  q_rdadr[$];
  logic [15:0] q_rx[$];

  bit          mon_en    = 1'b0;
  bit          auto_pop  = 1'b0;
  int          resp_mode = 0;
  int          fixed_lat = 3;
  bit          pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [15:0] pend_d    = '0;
  int          n_rd      = 0;
  int          n_rdy     = 0;

  typedef struct {
    logic        tx_wr;
    logic [15:0] txd;
    logic        rx_rd;
    logic [33:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [15:0] rdata(input logic [7:0] a);
    if (resp_mode == 0) return {7'b0, a, 1'b0};
    return {a ^ 8'hC3, a};
  endfunction

  task automatic monitor();
    logic [23:0] ew;
    logic [7:0]  ea;
    if (mon_en && bus.p_out_reg_wr) begin
      if (q_wr.size() == 0) fail("reg_wr", "write seen, none expected");
      else begin
        ew = q_wr.pop_front();
        chk("reg_wr", {bus.p_out_reg_adr, bus.p_out_reg_d}, ew);
      end
    end
    if (mon_en && bus.p_out_reg_rd) begin
      n_rd++;
      if (q_rdadr.size() == 0) fail("reg_rd", "read seen, none expected");
      else begin
        ea = q_rdadr.pop_front();
        chk("reg_rd_adr", bus.p_out_reg_adr, ea);
        pend_d = rdata(ea);
        if (resp_mode == 1 || (resp_mode == 2 && $urandom_range(0, 15) == 0)) begin
          q_rx.push_back(16'hDEAD);
        end else begin
          pend     = 1'b1;
          pend_cnt = (resp_mode == 0) ? fixed_lat - 1 : $urandom_range(0, 5);
          q_rx.push_back(pend_d);
        end
      end
    end
    bus.p_in_reg_rdy = 1'b0;
    bus.p_in_reg_d   = 16'($urandom);
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.p_in_reg_rdy = 1'b1;
        bus.p_in_reg_d   = pend_d;
        pend  = 1'b0;
        n_rdy++;
      end else pend_cnt--;
    end
  endtask

  task automatic cycle();
    logic [15:0] e;
    if (auto_pop && !bus.p_in_usr_rx_rd && bus.p_out_usr_status[0] &&
        $urandom_range(0, 2) == 0) begin
      if (q_rx.size() == 0) fail("rx_pop", "word present, none expected");
      else begin
        e = q_rx.pop_front();
        chk("rx_pop", bus.p_out_usr_rxd, e);
      end
      bus.p_in_usr_rx_rd = 1'b1;
    end
    @(posedge clk);
    #1;
    monitor();
    bus.p_in_usr_tx_wr = 1'b0;
    bus.p_in_usr_rx_rd = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    bus.p_in_usr_tx_wr = 1'b1;
    bus.p_in_usr_txd   = w;
    cycle();
  endtask

  task automatic do_pop(input logic [15:0] exp, input string name);
    chk(name, bus.p_out_usr_rxd, exp);
    bus.p_in_usr_rx_rd = 1'b1;
    cycle();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (bus.p_out_usr_status[2] && k < bound) begin
      cycle();
      k++;
    end
    if (bus.p_out_usr_status[2]) fail(name, "still busy after cycle budget");
  endtask

  task automatic wait_rd(input string name);
    int n0 = n_rd;
    int k  = 0;
    while (n_rd == n0 && k < 10) begin
      cycle();
      k++;
    end
    if (n_rd == n0) fail(name, "no reg_rd within budget");
  endtask

  task automatic drain(input string name);
    int k = 0;
    auto_pop = 1'b1;
    while (bus.p_out_usr_status[0] && k < 200) begin
      cycle();
      k++;
    end
    auto_pop = 1'b0;
    if (bus.p_out_usr_status[0]) fail(name, "FIFO not drained");
  endtask

  initial begin
    int          k;
    int          n0;
    logic [7:0]  adr;
    int          cnt;
    logic [15:0] w;

    bus.p_in_usr_tx_wr = 1'b0;
    bus.p_in_usr_txd   = '0;
    bus.p_in_usr_rx_rd = 1'b0;
    bus.p_in_reg_d     = '0;
    bus.p_in_reg_rdy   = 1'b0;

    // {reg_wr, reg_rd, reg_adr, reg_d, status} after each applied cycle
    tbl[0]  = '{1'b1, 16'h0210, 1'b0, {1'b0, 1'b0, 8'h00, 16'h0000, 8'h04}};
    tbl[1]  = '{1'b1, 16'h1111, 1'b0, {1'b1, 1'b0, 8'h10, 16'h1111, 8'h04}};
    tbl[2]  = '{1'b1, 16'h2222, 1'b0, {1'b1, 1'b0, 8'h11, 16'h2222, 8'h04}};
    tbl[3]  = '{1'b1, 16'h3333, 1'b0, {1'b1, 1'b0, 8'h12, 16'h3333, 8'h00}};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, {1'b0, 1'b0, 8'h12, 16'h3333, 8'h00}};
    tbl[5]  = '{1'b1, 16'h01FF, 1'b0, {1'b0, 1'b0, 8'h12, 16'h3333, 8'h04}};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, {1'b0, 1'b0, 8'h12, 16'h3333, 8'h04}};
    tbl[7]  = '{1'b1, 16'hAAAA, 1'b0, {1'b1, 1'b0, 8'hFF, 16'hAAAA, 8'h04}};
    tbl[8]  = '{1'b1, 16'h5555, 1'b0, {1'b1, 1'b0, 8'h00, 16'h5555, 8'h00}};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, {1'b0, 1'b0, 8'h00, 16'h5555, 8'h20}};
    tbl[10] = '{1'b1, 16'h0005, 1'b0, {1'b0, 1'b0, 8'h00, 16'h5555, 8'h24}};
    tbl[11] = '{1'b1, 16'h0BEE, 1'b0, {1'b1, 1'b0, 8'h05, 16'h0BEE, 8'h20}};

    repeat (3) cycle();
    rst = 1'b0;
    chk("reset_outputs", {bus.p_out_usr_rxd, bus.p_out_usr_status, bus.p_out_reg_adr,
                          bus.p_out_reg_d, bus.p_out_reg_wr, bus.p_out_reg_rd}, 50'h0);

    for (int i = 0; i < 12; i++) begin
      bus.p_in_usr_tx_wr = tbl[i].tx_wr;
      bus.p_in_usr_txd   = tbl[i].txd;
      bus.p_in_usr_rx_rd = tbl[i].rx_rd;
      cycle();
      chk($sformatf("table_row%0d", i),
          {bus.p_out_reg_wr, bus.p_out_reg_rd, bus.p_out_reg_adr,
           bus.p_out_reg_d, bus.p_out_usr_status}, tbl[i].exp);
    end

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    mon_en = 1'b1;

    // read packet of 4 words, data = adr*2, 3-cycle register latency
    resp_mode = 0;
    fixed_lat = 3;
    for (int i = 0; i < 4; i++) q_rdadr.push_back(8'h20 + 8'(i));
    send(16'h8320);
    wait_idle("rd_done", 100);
    chk("rd_status_full", bus.p_out_usr_status, 8'h03);
    for (int i = 0; i < 4; i++) do_pop(16'h0040 + 16'(2 * i), "rd_data");
    chk("rd_status_empty", bus.p_out_usr_status, 8'h00);
    chk("rd_rxd_hold", bus.p_out_usr_rxd, 16'h0046);
    q_rx.delete();

    // backpressure: 8-word read into a 4-deep FIFO with no pops
    fixed_lat = 1;
    n_rd = 0;
    for (int i = 0; i < 8; i++) q_rdadr.push_back(8'(i));
    send(16'h8700);
    repeat (40) cycle();
    chk("bp_reads_stalled", n_rd, 4);
    chk("bp_status", bus.p_out_usr_status, 8'h07);
    do_pop(16'h0000, "bp_pop");
    void'(q_rx.pop_front());
    repeat (20) cycle();
    chk("bp_one_more_read", n_rd, 5);
    chk("bp_status2", bus.p_out_usr_status, 8'h07);
    auto_pop = 1'b1;
    wait_idle("bp_done", 300);
    drain("bp_drain");
    chk("bp_rx_left", q_rx.size(), 0);

    // data arriving exactly at the timeout count wins; tx_wr in RWAIT flags proto_err
    fixed_lat = TMO + 1;
    q_rdadr.push_back(8'h41);
    send(16'h8041);
    wait_rd("edge_rd");
    send(16'h1234);
    wait_idle("edge_done", 100);
    chk("edge_status", bus.p_out_usr_status, 8'h09);
    do_pop(16'h0082, "edge_data");
    q_rx.delete();

    // no response at all: DEADs after TMO+1 cycles; header cleared proto_err
    resp_mode = 1;
    q_rdadr.push_back(8'h42);
    send(16'h8042);
    wait_rd("tmo_rd");
    k = 0;
    while (!bus.p_out_usr_status[0] && k < 100) begin
      cycle();
      k++;
    end
    chk("tmo_latency", k, TMO + 1);
    chk("tmo_status", bus.p_out_usr_status, 8'h11);
    do_pop(16'hDEAD, "tmo_data");
    q_rx.delete();
    bus.p_in_usr_rx_rd = 1'b1;
    cycle();
    chk("und_status", bus.p_out_usr_status, 8'h30);
    q_wr.push_back({8'h50, 16'h7777});
    send(16'h0050);
    chk("hdr_clears_status", bus.p_out_usr_status, 8'h24);
    send(16'h7777);
    chk("wr_after_err_status", bus.p_out_usr_status, 8'h20);

    // reset in the middle of a read packet with 2 words buffered
    resp_mode = 0;
    fixed_lat = 3;
    for (int i = 0; i < 4; i++) q_rdadr.push_back(8'h60 + 8'(i));
    n0 = n_rdy;
    send(16'h8360);
    k = 0;
    while (n_rdy < n0 + 2 && k < 50) begin
      cycle();
      k++;
    end
    cycle();
    chk("mid_status", bus.p_out_usr_status, 8'h25);
    pend = 1'b0;
    rst  = 1'b1;
    cycle();
    rst  = 1'b0;
    chk("mid_reset_outputs", {bus.p_out_usr_rxd, bus.p_out_usr_status, bus.p_out_reg_adr,
                              bus.p_out_reg_d, bus.p_out_reg_wr, bus.p_out_reg_rd}, 50'h0);
    q_rdadr.delete();
    q_rx.delete();
    q_wr.push_back({8'h70, 16'h0101});
    q_wr.push_back({8'h71, 16'h0202});
    send(16'h0170);
    send(16'h0101);
    send(16'h0202);
    chk("post_reset_status", bus.p_out_usr_status, 8'h00);
    chk("post_reset_writes", q_wr.size(), 0);

    // random packets against the transaction model
    resp_mode = 2;
    auto_pop  = 1'b1;
    for (int p = 0; p < 30; p++) begin
      wait_idle("rnd_idle", 2000);
      adr = 8'($urandom);
      cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0) begin
        send({1'b0, 7'(cnt), adr});
        for (int i = 0; i <= cnt; i++) begin
          w = 16'($urandom);
          q_wr.push_back({8'(adr + 8'(i)), w});
          repeat ($urandom_range(0, 2)) cycle();
          send(w);
        end
      end else begin
        for (int i = 0; i <= cnt; i++) q_rdadr.push_back(8'(adr + 8'(i)));
        send({1'b1, 7'(cnt), adr});
        wait_idle("rnd_rd_done", 2000);
      end
    end
    wait_idle("rnd_final", 2000);
    drain("rnd_drain");
    chk("rnd_writes_left", q_wr.size(), 0);
    chk("rnd_reads_left", q_rdadr.size(), 0);
    chk("rnd_rx_left", q_rx.size(), 0);
    chk("rnd_no_errors", bus.p_out_usr_status[5:3], 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
